// File: rtl/stateful_mem_sched_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// stateful_mem_sched_pkg : op codes, FSM states and page-table widths
// Revision: 1.0
// ------------------------------------------------------------------
package stateful_mem_sched_pkg;

  localparam int PAGE_BASE_W = 8;
  localparam int PAGE_LEN_W  = 8;

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_STORE = 2'b01;
  localparam logic [1:0] OP_LOADD = 2'b10;
  localparam logic [1:0] OP_NOP   = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_WAIT1 = 3'd2,
    ST_WAIT2 = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter_n.sv
`default_nettype none
// ------------------------------------------------------------------
// rr_arbiter_n : combinational round-robin picker, search starts after last
// Revision: 1.0
// ------------------------------------------------------------------
module rr_arbiter_n #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  input  logic          en,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx
);

  logic          hi_found;
  logic [IW-1:0] hi_idx;
  logic [IW-1:0] lo_idx;

  // Descending scan leaves the lowest requester overall and the lowest one above last.
  always_comb begin
    hi_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        lo_idx = IW'(i);
        if (i > int'(last)) begin
          hi_found = 1'b1;
          hi_idx   = IW'(i);
        end
      end
    end
  end

  assign idx   = hi_found ? hi_idx : lo_idx;
  assign grant = (en && (|req)) ? (N'(1) << idx) : '0;

endmodule
`default_nettype wire

// File: rtl/stateful_mem_sched.sv
`default_nettype none
// ------------------------------------------------------------------
// stateful_mem_sched : round-robin, tenant-isolated access to a shared stateful RAM
// Revision: 1.0
// ------------------------------------------------------------------
module stateful_mem_sched
  import stateful_mem_sched_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int ID_WIDTH   = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [N_REQ-1:0]              req_valid,
  output logic [N_REQ-1:0]              req_ready,
  input  logic [2*N_REQ-1:0]            req_op,
  input  logic [ADDR_WIDTH*N_REQ-1:0]   req_addr,
  input  logic [DATA_WIDTH*N_REQ-1:0]   req_wdata,
  input  logic [PAGE_BASE_W*N_REQ-1:0]  req_base,
  input  logic [PAGE_LEN_W*N_REQ-1:0]   req_len,
  output logic                          resp_valid,
  output logic [ID_WIDTH-1:0]           resp_id,
  output logic [DATA_WIDTH-1:0]         resp_data,
  output logic                          resp_overflow,
  output logic                          ram_wea,
  output logic [ADDR_WIDTH-1:0]         ram_addra,
  output logic [DATA_WIDTH-1:0]         ram_dina,
  output logic [ADDR_WIDTH-1:0]         ram_addrb,
  input  logic [DATA_WIDTH-1:0]         ram_doutb
);

  state_t                  state;
  logic [ID_WIDTH-1:0]     rr_ptr;
  logic [ID_WIDTH-1:0]     grant_idx;
  logic [N_REQ-1:0]        grant;
  logic [1:0]              op_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [ID_WIDTH-1:0]     id_q;
  logic                    ovf_q;

  logic [1:0]              sel_op;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic [DATA_WIDTH-1:0]   sel_wdata;
  logic [PAGE_BASE_W-1:0]  sel_base;
  logic [PAGE_LEN_W-1:0]   sel_len;
  logic                    chk_ovf;
  logic [ADDR_WIDTH-1:0]   chk_phys;

  rr_arbiter_n #(
    .N  (N_REQ),
    .IW (ID_WIDTH)
  ) u_arb (
    .req   (req_valid),
    .last  (rr_ptr),
    .en    (state == ST_IDLE),
    .grant (grant),
    .idx   (grant_idx)
  );

  assign req_ready = grant;

  always_comb begin
    sel_op    = '0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_base  = '0;
    sel_len   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        sel_op    = req_op[2*i +: 2];
        sel_addr  = req_addr[ADDR_WIDTH*i +: ADDR_WIDTH];
        sel_wdata = req_wdata[DATA_WIDTH*i +: DATA_WIDTH];
        sel_base  = req_base[PAGE_BASE_W*i +: PAGE_BASE_W];
        sel_len   = req_len[PAGE_LEN_W*i +: PAGE_LEN_W];
      end
    end
  end

  // The bounds check and translation are evaluated on the granted fields so that
  // the RAM port registers already hold the physical address during CHECK.
  assign chk_ovf  = PAGE_LEN_W'(sel_addr) > sel_len;
  assign chk_phys = ADDR_WIDTH'(sel_base + PAGE_BASE_W'(sel_addr));

  // Read data only arrives in WAIT2, so the increment-writeback data bypasses the register.
  assign ram_dina = (state == ST_WAIT2 && op_q == OP_LOADD) ? ram_doutb + DATA_WIDTH'(1)
                                                            : wdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      rr_ptr        <= ID_WIDTH'(N_REQ - 1);
      op_q          <= '0;
      wdata_q       <= '0;
      id_q          <= '0;
      ovf_q         <= 1'b0;
      resp_valid    <= 1'b0;
      resp_id       <= '0;
      resp_data     <= '0;
      resp_overflow <= 1'b0;
      ram_wea       <= 1'b0;
      ram_addra     <= '0;
      ram_addrb     <= '0;
    end else begin
      ram_wea    <= 1'b0;
      resp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (|grant) begin
            op_q      <= sel_op;
            wdata_q   <= sel_wdata;
            id_q      <= grant_idx;
            ovf_q     <= chk_ovf;
            ram_addra <= chk_phys;
            ram_addrb <= chk_phys;
            ram_wea   <= !chk_ovf && (sel_op == OP_STORE);
            state     <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (!ovf_q && (op_q == OP_LOAD || op_q == OP_LOADD)) begin
            state <= ST_WAIT1;
          end else begin
            resp_valid    <= 1'b1;
            resp_id       <= id_q;
            resp_overflow <= ovf_q;
            resp_data     <= (!ovf_q && op_q == OP_STORE) ? wdata_q : '0;
            state         <= ST_DONE;
          end
        end
        ST_WAIT1: begin
          ram_wea <= (op_q == OP_LOADD);
          state   <= ST_WAIT2;
        end
        ST_WAIT2: begin
          resp_valid    <= 1'b1;
          resp_id       <= id_q;
          resp_overflow <= 1'b0;
          resp_data     <= (op_q == OP_LOADD) ? ram_doutb + DATA_WIDTH'(1) : ram_doutb;
          state         <= ST_DONE;
        end
        ST_DONE: begin
          rr_ptr <= id_q;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_stateful_mem_sched.sv
`default_nettype none
`timescale 1ns/1ps
// ------------------------------------------------------------------
// tb_stateful_mem_sched : directed + random stimulus against a transaction-level model
// Revision: 1.0
// ------------------------------------------------------------------
module tb_stateful_mem_sched;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int IW = 2;
  localparam int DEPTH = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]    req_valid, req_ready;
  logic [2*N-1:0]  req_op;
  logic [AW*N-1:0] req_addr;
  logic [DW*N-1:0] req_wdata;
  logic [8*N-1:0]  req_base, req_len;
  logic            resp_valid, resp_overflow, ram_wea;
  logic [IW-1:0]   resp_id;
  logic [DW-1:0]   resp_data, ram_dina, ram_doutb;
  logic [AW-1:0]   ram_addra, ram_addrb;

  // per-requester stimulus
  logic [N-1:0]  s_v;
  logic [1:0]    s_op   [N];
  logic [AW-1:0] s_addr [N];
  logic [DW-1:0] s_wd   [N];
  logic [7:0]    s_base [N];
  logic [7:0]    s_len  [N];

  always_comb begin
    req_valid = s_v;
    req_op = '0; req_addr = '0; req_wdata = '0; req_base = '0; req_len = '0;
    for (int i = 0; i < N; i++) begin
      req_op[2*i +: 2]     = s_op[i];
      req_addr[AW*i +: AW] = s_addr[i];
      req_wdata[DW*i +: DW] = s_wd[i];
      req_base[8*i +: 8]   = s_base[i];
      req_len[8*i +: 8]    = s_len[i];
    end
  end

  stateful_mem_sched #(.N_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_base(req_base), .req_len(req_len),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_data(resp_data), .resp_overflow(resp_overflow),
    .ram_wea(ram_wea), .ram_addra(ram_addra), .ram_dina(ram_dina),
    .ram_addrb(ram_addrb), .ram_doutb(ram_doutb)
  );

  // RAM: write port A, read port B with two cycles of latency, no bypass
  logic [DW-1:0] ram [DEPTH];
  logic [AW-1:0] ra1;
  always @(posedge clk) begin
    if (ram_wea) ram[ram_addra] <= ram_dina;
    ra1       <= ram_addrb;
    ram_doutb <= ram[ra1];
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // transaction-level reference model
  logic [DW-1:0] ref_mem [DEPTH];
  int            cyc = 0;
  int            hs_count = 0;
  bit            m_busy = 1'b0;
  int            m_last = N - 1;
  int            m_resp_cyc, m_wr_cyc, m_id, m_wr_addr;
  bit            m_wr_en, m_ovf;
  logic [DW-1:0] m_data, m_wr_data;
  logic [N-1:0]  sb_rdy;
  int            sb_g, sb_phys;
  bit            sb_exp_w, sb_exp_r;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_busy = 1'b0;
      m_last = N - 1;
    end else begin
      cyc++;
      sb_rdy = '0;
      sb_g   = -1;
      if (!m_busy && s_v != '0) begin
        for (int k = 1; k <= N; k++)
          if (sb_g < 0 && s_v[(m_last + k) % N]) sb_g = (m_last + k) % N;
        sb_rdy[sb_g] = 1'b1;
      end
      check_eq("req_ready", req_ready, sb_rdy);

      sb_exp_w = m_busy && m_wr_en && (cyc == m_wr_cyc);
      check_eq("ram_wea", ram_wea, sb_exp_w);
      if (sb_exp_w) begin
        check_eq("ram_addra", ram_addra, m_wr_addr);
        check_eq("ram_dina", ram_dina, m_wr_data);
      end

      sb_exp_r = m_busy && (cyc == m_resp_cyc);
      check_eq("resp_valid", resp_valid, sb_exp_r);
      if (sb_exp_r) begin
        check_eq("resp_id", resp_id, m_id);
        check_eq("resp_data", resp_data, m_data);
        check_eq("resp_overflow", resp_overflow, m_ovf);
        if (m_wr_en) ref_mem[m_wr_addr] = m_wr_data;
        m_busy = 1'b0;
      end

      if (sb_g >= 0) begin
        m_ovf   = int'(s_addr[sb_g]) > int'(s_len[sb_g]);
        sb_phys = (int'(s_base[sb_g]) + int'(s_addr[sb_g])) % DEPTH;
        m_busy  = 1'b1;
        m_id    = sb_g;
        m_last  = sb_g;
        m_wr_en = 1'b0;
        if (m_ovf || s_op[sb_g] == 2'b11) begin
          m_resp_cyc = cyc + 2;
          m_data     = '0;
        end else if (s_op[sb_g] == 2'b01) begin
          m_resp_cyc = cyc + 2;
          m_data     = s_wd[sb_g];
          m_wr_en    = 1'b1;
          m_wr_cyc   = cyc + 1;
          m_wr_addr  = sb_phys;
          m_wr_data  = s_wd[sb_g];
        end else if (s_op[sb_g] == 2'b00) begin
          m_resp_cyc = cyc + 4;
          m_data     = ref_mem[sb_phys];
        end else begin
          m_resp_cyc = cyc + 4;
          m_data     = ref_mem[sb_phys] + 32'd1;
          m_wr_en    = 1'b1;
          m_wr_cyc   = cyc + 3;
          m_wr_addr  = sb_phys;
          m_wr_data  = m_data;
        end
        hs_count++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [1:0] op, input int a, input logic [DW-1:0] wd,
                         input int b, input int l);
    s_v[i]    = 1'b1;
    s_op[i]   = op;
    s_addr[i] = AW'(a);
    s_wd[i]   = wd;
    s_base[i] = 8'(b);
    s_len[i]  = 8'(l);
  endtask

  task automatic do_req(input int i, input logic [1:0] op, input int a, input logic [DW-1:0] wd,
                        input int b, input int l);
    int start;
    int t;
    start = hs_count;
    t = 0;
    set_req(i, op, a, wd, b, l);
    while (hs_count == start && t < 20) begin
      step();
      t++;
    end
    if (hs_count == start) check_eq("handshake_timeout", 0, 1);
    s_v[i] = 1'b0;
  endtask

  task automatic settle();
    repeat (6) step();
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_ready"}, req_ready, 0);
    check_eq({tag, "_resp"}, {resp_valid, resp_id, resp_data, resp_overflow}, 0);
    check_eq({tag, "_ram"}, {ram_wea, ram_addra, ram_dina, ram_addrb}, 0);
  endtask

  initial begin
    for (int j = 0; j < DEPTH; j++) begin
      ram[j] = '0;
      ref_mem[j] = '0;
    end
    ra1 = '0;
    ram_doutb = '0;
    s_v = '0;
    for (int i = 0; i < N; i++) begin
      s_op[i] = 2'b11; s_addr[i] = '0; s_wd[i] = '0; s_base[i] = '0; s_len[i] = '0;
    end

    repeat (2) step();
    check_outputs_zero("reset");
    rst_n = 1'b1;
    step();

    // store then load through tenant base 8
    do_req(0, 2'b01, 3, 32'hDEADBEEF, 8, 15);
    settle();
    do_req(0, 2'b00, 3, 32'h0, 8, 15);
    settle();

    // load-increment sequences including wrap of the data word
    do_req(1, 2'b01, 3, 32'h7, 8, 15);
    settle();
    do_req(1, 2'b10, 3, 32'h0, 8, 15);
    settle();
    do_req(2, 2'b10, 11, 32'h0, 0, 31);
    settle();
    do_req(2, 2'b01, 11, 32'hFFFFFFFF, 0, 31);
    settle();
    do_req(3, 2'b10, 11, 32'h0, 0, 31);
    settle();

    // bounds: over, just over, exactly at the limit
    do_req(0, 2'b00, 20, 32'h0, 0, 15);
    settle();
    do_req(1, 2'b01, 16, 32'h12345678, 0, 15);
    settle();
    do_req(2, 2'b01, 15, 32'hCAFEF00D, 0, 15);
    settle();
    do_req(2, 2'b00, 15, 32'h0, 0, 15);
    settle();

    // address translation wrap, then read back through base 0
    do_req(3, 2'b01, 3, 32'h55, 30, 31);
    settle();
    do_req(0, 2'b00, 1, 32'h0, 0, 31);
    settle();
    do_req(1, 2'b11, 2, 32'h0, 0, 31);
    settle();

    // all requesters asserting loads continuously
    for (int i = 0; i < N; i++) set_req(i, 2'b00, i + 1, 32'h0, 0, 31);
    repeat (30) step();
    s_v = '0;
    settle();

    // asynchronous reset in WAIT1 of a load-increment
    do_req(0, 2'b10, 11, 32'h0, 0, 31);
    step();
    rst_n = 1'b0;
    #1;
    check_outputs_zero("midreset");
    repeat (2) step();
    rst_n = 1'b1;
    step();
    for (int i = 0; i < N; i++) set_req(i, 2'b00, i, 32'h0, 0, 31);
    @(negedge clk);
    #1;
    check_eq("first_grant_after_reset", req_ready, 4'b0001);
    step();
    s_v = '0;
    settle();

    // randomized traffic
    for (int c = 0; c < 500; c++) begin
      for (int i = 0; i < N; i++) begin
        s_v[i]    = ($urandom_range(0, 9) < 6);
        s_op[i]   = 2'($urandom_range(0, 3));
        s_addr[i] = AW'($urandom_range(0, DEPTH - 1));
        s_wd[i]   = $urandom;
        s_base[i] = 8'($urandom_range(0, 255));
        s_len[i]  = 8'($urandom_range(0, 40));
      end
      step();
    end
    s_v = '0;
    settle();

    check_eq("drained", m_busy, 0);
    for (int j = 0; j < DEPTH; j++) check_eq("ram_contents", ram[j], ref_mem[j]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/stateful_mem_sched.md
Name: stateful_mem_sched

Overview:
- Shares one stateful key-value RAM (32 words x 32 bit, 2-cycle read latency, separate write port A / read port B) among N_REQ action-stage ALU requesters.
- Accepts load, store and loadd (load, increment, write back) requests and arbitrates them round-robin.
- Applies per-tenant isolation: bounds check against the tenant length, then base-offset address translation.
- Sequences the RAM ports and returns one response per accepted request.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- DATA_WIDTH, 32, RAM word width.
- ADDR_WIDTH, 5, RAM address width (depth 2^ADDR_WIDTH).
- ID_WIDTH, 2, requester id width; must satisfy 2^ID_WIDTH >= N_REQ.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; one clock, asynchronous active-low reset
- req_valid  in  N_REQ  per-requester request valid
- req_ready  out  N_REQ  one-hot grant; combinational from state and req_valid
- req_op  in  2*N_REQ  per requester: 00 load, 01 store, 10 loadd, 11 nop
- req_addr  in  ADDR_WIDTH*N_REQ  tenant-relative address
- req_wdata  in  DATA_WIDTH*N_REQ  store data
- req_base  in  8*N_REQ  tenant base address (from page table)
- req_len  in  8*N_REQ  tenant max legal offset
- resp_valid  out  1  one-cycle response strobe
- resp_id  out  ID_WIDTH  requester the response belongs to
- resp_data  out  DATA_WIDTH  result data
- resp_overflow  out  1  bounds violation flag
- ram_wea  out  1  RAM write enable
- ram_addra  out  ADDR_WIDTH  RAM write address
- ram_dina  out  DATA_WIDTH  RAM write data
- ram_addrb  out  ADDR_WIDTH  RAM read address
- ram_doutb  in  DATA_WIDTH  RAM read data; valid 2 cycles after ram_addrb

Behaviour:
- FSM states: IDLE, CHECK, WAIT1, WAIT2, DONE. One request is in flight at a time; there is no pipelining.
- IDLE:
  - If any req_valid is high, grant the first valid index searched from rr_ptr+1 upward, wrapping.
  - req_ready[grant]=1 in this cycle only; that cycle is the handshake.
  - Latch op, addr, wdata, base, len and id, then go to CHECK.
  - req_ready is 0 in every other state.
- CHECK:
  - ovf = ({3'b0,addr} > len); the comparison is unsigned 8-bit.
  - phys = (base + addr) truncated to ADDR_WIDTH bits; it wraps modulo depth.
  - Register phys into ram_addra and ram_addrb.
  - If ovf or op=nop: go to DONE, with no RAM access.
  - If store: ram_wea=1, ram_dina=wdata, go to DONE.
  - If load or loadd: go to WAIT1.
- WAIT1: go to WAIT2.
- WAIT2:
  - ram_doutb is valid in this cycle; latch it as rdata.
  - If loadd: ram_wea=1, ram_addra=phys, ram_dina=rdata+1 (wraps at 2^DATA_WIDTH).
  - Go to DONE.
- DONE:
  - resp_valid=1 for exactly this cycle, with resp_id = latched id.
  - resp_data: load gives rdata; loadd gives rdata+1; store gives wdata; overflow or nop gives 0.
  - resp_overflow = ovf.
  - rr_ptr <= id. Go to IDLE.
- ram_wea is high only in CHECK (non-overflowing store) and in WAIT2 (loadd); it is never high otherwise.
- Latency from the handshake cycle T:
  - store, overflow, nop: resp_valid at T+2.
  - load, loadd: resp_valid at T+4.
  - The next grant is possible at T+3 or T+5 respectively.
- Read-after-write: a following read of an address just written is always at least 2 cycles after the write, so no bypass is required.
- Requests of overflowing ops never touch the RAM.
- Request fields are sampled only in the grant cycle. A requester may drop req_valid before it is granted; the block ignores it.
- Reset (asynchronous, any state including mid-operation):
  - state=IDLE, rr_ptr=N_REQ-1 (so requester 0 wins first).
  - All outputs 0: resp_*, ram_wea, ram_addra, ram_dina, ram_addrb.
  - Latched fields cleared; the aborted request gets no response and produces no write.

Decomposition:
- Shared package holds:
  - op encodings OP_LOAD, OP_STORE, OP_LOADD, OP_NOP;
  - the FSM state enum;
  - the constants PAGE_BASE_W = 8 and PAGE_LEN_W = 8.
- Natural sub-module rr_arbiter_n:
  - inputs: req vector, last pointer, enable;
  - outputs: one-hot grant and binary index;
  - purely combinational.

Test Plan:
1. Req0 store addr 3, wdata 0xDEADBEEF, base 8, len 15 at T -> ram_wea at T+1 with ram_addra 11; resp_valid at T+2, id 0, data 0xDEADBEEF, overflow 0. Then req0 load addr 3 -> resp_data 0xDEADBEEF 4 cycles after its grant.
2. Loadd addr 11 holding 0x00000007 -> write of 0x8 to addr 11 in WAIT2; resp_data 0x8. A second loadd -> 0x9. Loadd on 0xFFFFFFFF -> 0x0.
3. Load addr 20 with len 15 -> resp_overflow 1, data 0, ram_wea never asserted, response at T+2. Store with addr 16, len 15 -> overflow, no write. addr 15, len 15 -> legal.
4. All 4 requesters hold req_valid continuously with loads -> grants in order 0,1,2,3,0,1; each grant one cycle; resp_id matches the grant order.
5. Wrap: base 30, addr 3, len 31, store 0x55 -> ram_addra 1. A load of addr 1 with base 0 returns 0x55.
6. Assert rst_n low during WAIT1 of a loadd -> all outputs 0 immediately. No write and no resp_valid afterwards. After release, the first grant goes to requester 0.
